// File: rtl/msg_wr_arbiter_if.sv
// Requester handshake and message-memory write port of msg_wr_arbiter.
// The arbiter takes the master view. Requesters and memory share the slave view.
interface msg_wr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_last;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    gnt;
   logic               wr;
   logic [DW-1:0]      dat;
   logic               disp;
   logic               busy;
   logic               err_trunc;

   modport master (
      input  req_valid, req_last, req_data,
      output req_ready, gnt, wr, dat, disp, busy, err_trunc
   );

   modport slave (
      output req_valid, req_last, req_data,
      input  req_ready, gnt, wr, dat, disp, busy, err_trunc
   );
endinterface

// File: rtl/msg_wr_arbiter.sv
// Round-robin message arbiter for the shared byte-write/display port.
// A grant is held for a whole message. The granted bytes are forwarded as
// registered wr/dat pulses. After the last byte the arbiter waits GAP cycles,
// then pulses disp. Messages that reach MAXLEN bytes without a last marker are cut.
module msg_wr_arbiter #(
   parameter int NREQ   = 4,
   parameter int DW     = 8,
   parameter int GAP    = 3,
   parameter int MAXLEN = 32
) (
   input  logic             clk,
   input  logic             rst_b,
   msg_wr_arbiter_if.master bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAXLEN + 1);
   localparam int GW = $clog2(GAP + 1);

   typedef enum logic [1:0] {IDLE, XFER, WAIT, DISP} state_t;

   state_t          state_reg, state_next;
   logic [NREQ-1:0] gnt_reg, gnt_next;
   logic [IW-1:0]   gidx_reg, gidx_next;
   logic [IW-1:0]   last_grant_reg, last_grant_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [GW-1:0]   gap_reg, gap_next;
   logic            wr_reg, wr_next;
   logic [DW-1:0]   dat_reg, dat_next;
   logic            disp_reg, disp_next;
   logic            busy_reg, busy_next;
   logic            err_reg, err_next;

   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic [IW:0]     cand;
   logic            hs;
   logic            g_last;
   logic [DW-1:0]   g_data;
   logic [CW-1:0]   cnt_inc;
   logic [DW-1:0]   data_arr [NREQ];

   // Per-requester byte lanes and ready bits. Ready is a decode of state and grant only.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
         assign data_arr[gi]      = bus.req_data[gi*DW +: DW];
         assign bus.req_ready[gi] = (state_reg == XFER) && gnt_reg[gi];
      end
   endgenerate

   assign hs     = (state_reg == XFER) && ((bus.req_valid & gnt_reg) != '0);
   assign g_last = bus.req_last[gidx_reg];
   assign g_data = data_arr[gidx_reg];

   // Round-robin search: the nearest valid requester above the previous grant wins.
   // The loop walks from the farthest offset down, so the nearest offset is written last.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = {1'b0, last_grant_reg} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (bus.req_valid[cand[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IW-1:0];
         end
      end
   end

   // Next-state and next-output logic for the IDLE/XFER/WAIT/DISP sequence.
   always_comb begin
      state_next      = state_reg;
      gnt_next        = gnt_reg;
      gidx_next       = gidx_reg;
      last_grant_next = last_grant_reg;
      cnt_next        = cnt_reg;
      gap_next        = gap_reg;
      wr_next         = 1'b0;
      dat_next        = '0;
      err_next        = 1'b0;
      cnt_inc         = cnt_reg + 1'b1;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               state_next         = XFER;
               gidx_next          = pick_idx;
               gnt_next           = '0;
               gnt_next[pick_idx] = 1'b1;
            end
         end
         XFER: begin
            if (hs) begin
               wr_next  = 1'b1;
               dat_next = g_data;
               cnt_next = cnt_inc;
               if (g_last) begin
                  state_next = WAIT;
                  gap_next   = '0;
               end else if (cnt_inc == CW'(MAXLEN)) begin
                  state_next = WAIT;
                  gap_next   = '0;
                  err_next   = 1'b1;
               end
            end
         end
         WAIT: begin
            // The first WAIT cycle still shows the final wr, so the gap count starts at zero there.
            if (gap_reg == GW'(GAP)) begin
               state_next = DISP;
            end else begin
               gap_next = gap_reg + 1'b1;
            end
         end
         DISP: begin
            state_next      = IDLE;
            gnt_next        = '0;
            cnt_next        = '0;
            last_grant_next = gidx_reg;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      disp_next = (state_next == DISP);
      busy_next = (state_next != IDLE);
   end

   // State and output registers. An asynchronous reset aborts any message in flight.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg      <= IDLE;
         gnt_reg        <= '0;
         gidx_reg       <= '0;
         last_grant_reg <= IW'(NREQ - 1);
         cnt_reg        <= '0;
         gap_reg        <= '0;
         wr_reg         <= 1'b0;
         dat_reg        <= '0;
         disp_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         gnt_reg        <= gnt_next;
         gidx_reg       <= gidx_next;
         last_grant_reg <= last_grant_next;
         cnt_reg        <= cnt_next;
         gap_reg        <= gap_next;
         wr_reg         <= wr_next;
         dat_reg        <= dat_next;
         disp_reg       <= disp_next;
         busy_reg       <= busy_next;
         err_reg        <= err_next;
      end
   end

   assign bus.gnt       = gnt_reg;
   assign bus.wr        = wr_reg;
   assign bus.dat       = dat_reg;
   assign bus.disp      = disp_reg;
   assign bus.busy      = busy_reg;
   assign bus.err_trunc = err_reg;
endmodule

// File: doc/msg_wr_arbiter.md
Name: msg_wr_arbiter

Overview:
- Shares the byte-write/display port of the message memory (rst_b, clk, wr, dat[7:0], disp) between NREQ requesters.
- Each requester pushes one message at a time as a byte stream using a valid/ready/last handshake.
- The arbiter grants whole messages in round-robin order and forwards the bytes as registered wr/dat pulses.
- After each message it waits GAP cycles, then issues a one-cycle disp pulse so the memory displays its content.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data byte width
GAP, 3, idle cycles between the last write and the disp pulse (>=1)
MAXLEN, 32, maximum bytes per message; longer messages are truncated

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester byte valid
req_last  input  NREQ  per-requester last-byte marker, qualified by valid
req_data  input  NREQ*DW  per-requester byte; requester i occupies bits [i*DW +: DW]
req_ready  output  NREQ  per-requester accept, combinational
gnt  output  NREQ  one-hot current grant, registered
wr  output  1  memory write strobe, registered
dat  output  DW  memory write byte, registered
disp  output  1  memory display pulse, registered
busy  output  1  high in any state other than IDLE
err_trunc  output  1  one-cycle pulse when a message is cut at MAXLEN

Behaviour:
- Reset: rst_b low asynchronously forces state=IDLE, gnt=0, wr=0, dat=0, disp=0, err_trunc=0, byte count=0, last_grant=NREQ-1. Requester 0 therefore has the highest priority after reset.
- FSM states are IDLE, XFER, WAIT, DISP.
- IDLE:
  - If any req_valid is high, pick the first asserted requester searching from last_grant+1 upward, wrapping modulo NREQ.
  - Register gnt to that requester and go to XFER. The grant therefore takes effect 1 cycle after valid is seen.
  - req_ready is all zero in IDLE.
- XFER:
  - req_ready[g]=1 for the granted index only; all other ready bits are 0.
  - A handshake (req_valid[g] & req_ready[g]) produces wr=1 and dat=req_data[g] on the next cycle (1-cycle latency). The byte count increments on each handshake.
  - A cycle with no handshake produces wr=0 and dat=0 on the next cycle. Valid bubbles are allowed, and the grant is held across them.
  - A handshake with req_last[g]=1 moves the FSM to WAIT.
  - A handshake where the count reaches MAXLEN without last moves the FSM to WAIT and pulses err_trunc on the next cycle, together with the final wr.
  - After truncation, the remaining bytes of that message belong to the requester's next message; this is the requester's problem.
- WAIT:
  - wr=0, dat=0, req_ready=0.
  - Stays exactly GAP cycles, counted from the cycle after the final wr, then moves to DISP.
- DISP:
  - disp=1 for exactly one cycle.
  - last_grant is set to g, gnt is cleared, the byte count is cleared, and the FSM returns to IDLE.
  - A new grant can be registered in the cycle after DISP, so a back-to-back message's first wr comes at the earliest 3 cycles after disp.
- Messages never interleave: the grant is locked from grant to DISP. Requests arriving mid-message wait.
- req_last with req_valid low is ignored. req_valid/req_last on non-granted requesters have no effect.
- A single-byte message (valid & last on the first handshake) is legal: one wr, then WAIT.
- The byte counter is clog2(MAXLEN+1) bits wide and never wraps.
- Reset asserted mid-message aborts immediately: no further wr, no disp. After release, arbitration restarts with requester 0 highest priority.
- All outputs except req_ready are flop outputs. req_ready depends only on state and gnt, never on req_valid.

Test Plan:
1. Requester 0 sends "Hi" (0x48, 0x69, last on 0x69), NREQ=4, GAP=3 -> gnt=0001. wr high for 2 consecutive cycles with dat 0x48 then 0x69. Then 3 cycles of wr=0, then disp=1 for one cycle, then busy=0.
2. Requesters 1 and 2 both assert valid in the same IDLE cycle after reset, 1-byte messages 0xA1 and 0xB2 -> 0xA1 is written first with its disp, then 0xB2 with its disp. No interleave.
3. Round-robin fairness: requesters 0 and 3 request continuously with 2-byte messages -> grant order 0,3,0,3. req_ready is never high for the non-granted requester.
4. Requester 2 sends 0x41, drops valid for 4 cycles, then sends 0x42 with last -> wr pulses separated by 4 idle cycles. gnt stays 0100 throughout, followed by one disp.
5. MAXLEN=4, requester 0 sends 6 bytes 0x01..0x06 with last on 0x06 -> exactly 4 wr (0x01..0x04). err_trunc pulses with the 0x04 write, then disp. Bytes 0x05/0x06 form the next message.
6. rst_b pulsed low for 1 cycle after the 2nd byte of "Hello" -> wr, dat, disp, gnt and busy go to 0 immediately. No disp for the aborted message. A fresh request after release starts with requester 0 priority.
